// File: rtl/afu_rd_req_split.sv
// Splits one multi-CL burst read into single-CL reads, bounded by almost-full and read credits.
// Optional stall counters are built when RD_SPLIT_PERF_EN is defined.
module afu_rd_req_split #(
    parameter int unsigned MAX_OUTSTANDING = 64,
    parameter int unsigned CNT_W           = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cor_tx_rd_valid,
    input  logic [57:0]      cor_tx_rd_addr,
    input  logic [5:0]       cor_tx_rd_len,
    output logic             cor_tx_rd_ready,
    input  logic             spl_tx_rd_almostfull,
    output logic             io_tx_rd_valid,
    output logic [57:0]      io_tx_rd_addr,
    output logic [5:0]       io_tx_rd_len,
    input  logic             io_rx_rd_valid,
    output logic [CNT_W-1:0] rd_outstanding,
    output logic             rd_idle,
    output logic             rd_err,
    output logic [31:0]      rd_stall_af_cnt,
    output logic [31:0]      rd_stall_cr_cnt
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    state_e           state_q, state_d;
    logic [57:0]      cur_addr_q, cur_addr_d;
    logic [6:0]       remaining_q, remaining_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             rsp_mask_q;
    logic             io_valid_q;
    logic [57:0]      io_addr_q;
    logic             idle_q;
    logic             has_credit;
    logic             fire;
    logic             rsp;

    always_comb begin
        has_credit  = cnt_q < MaxCnt;
        fire        = (state_q == StIssue) && !spl_tx_rd_almostfull && has_credit;
        // Responses landing right after reset belong to the abandoned traffic.
        rsp         = io_rx_rd_valid && !rsp_mask_q;
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        cnt_d       = cnt_q;
        err_d       = err_q;

        case (state_q)
            StIdle: begin
                if (cor_tx_rd_valid) begin
                    cur_addr_d  = cor_tx_rd_addr;
                    remaining_d = (cor_tx_rd_len == 6'd0) ? 7'd64 : {1'b0, cor_tx_rd_len};
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (fire) begin
                    cur_addr_d  = cur_addr_q + 58'd1;
                    remaining_d = remaining_q - 7'd1;
                    if (remaining_q == 7'd1) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (fire && !rsp) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (rsp && !fire) begin
            if (cnt_q == '0) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            rsp_mask_q  <= 1'b1;
            io_valid_q  <= 1'b0;
            io_addr_q   <= '0;
            idle_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            rsp_mask_q  <= 1'b0;
            io_valid_q  <= fire;
            if (fire) begin
                io_addr_q <= cur_addr_q;
            end
            idle_q      <= (state_d == StIdle) && (cnt_d == '0);
        end
    end

`ifdef RD_SPLIT_PERF_EN
    logic [31:0] af_cnt_q;
    logic [31:0] cr_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            af_cnt_q <= '0;
            cr_cnt_q <= '0;
        end else if (state_q == StIssue) begin
            if (spl_tx_rd_almostfull) begin
                if (af_cnt_q != 32'hFFFF_FFFF) af_cnt_q <= af_cnt_q + 32'd1;
            end else if (!has_credit) begin
                if (cr_cnt_q != 32'hFFFF_FFFF) cr_cnt_q <= cr_cnt_q + 32'd1;
            end
        end
    end

    assign rd_stall_af_cnt = af_cnt_q;
    assign rd_stall_cr_cnt = cr_cnt_q;
`else
    assign rd_stall_af_cnt = 32'd0;
    assign rd_stall_cr_cnt = 32'd0;
`endif

    assign cor_tx_rd_ready = (state_q == StIdle);
    assign io_tx_rd_valid  = io_valid_q;
    assign io_tx_rd_addr   = io_addr_q;
    assign io_tx_rd_len    = 6'd1;
    assign rd_outstanding  = cnt_q;
    assign rd_idle         = idle_q;
    assign rd_err          = err_q;

endmodule

// File: tb/tb_afu_rd_req_split.sv
// Bench for afu_rd_req_split: two instances (64 and 2 credits) against a burst-queue reference model.
// Stall-counter expectations follow RD_SPLIT_PERF_EN.
module tb_afu_rd_req_split;

    localparam int N = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic                 af;
    logic [N-1:0]         cv;
    logic [N-1:0][57:0]   ca;
    logic [N-1:0][5:0]    cl;
    logic [N-1:0]         rsp;
    logic [N-1:0]         ready;
    logic [N-1:0]         iov;
    logic [N-1:0][57:0]   ioa;
    logic [N-1:0][5:0]    iol;
    logic [N-1:0][6:0]    ocnt;
    logic [N-1:0]         idle;
    logic [N-1:0]         err;
    logic [N-1:0][31:0]   saf;
    logic [N-1:0][31:0]   scr;

    afu_rd_req_split #(.MAX_OUTSTANDING(64), .CNT_W(7)) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .cor_tx_rd_valid(cv[0]), .cor_tx_rd_addr(ca[0]), .cor_tx_rd_len(cl[0]),
        .cor_tx_rd_ready(ready[0]), .spl_tx_rd_almostfull(af),
        .io_tx_rd_valid(iov[0]), .io_tx_rd_addr(ioa[0]), .io_tx_rd_len(iol[0]),
        .io_rx_rd_valid(rsp[0]), .rd_outstanding(ocnt[0]), .rd_idle(idle[0]), .rd_err(err[0]),
        .rd_stall_af_cnt(saf[0]), .rd_stall_cr_cnt(scr[0])
    );

    afu_rd_req_split #(.MAX_OUTSTANDING(2), .CNT_W(7)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .cor_tx_rd_valid(cv[1]), .cor_tx_rd_addr(ca[1]), .cor_tx_rd_len(cl[1]),
        .cor_tx_rd_ready(ready[1]), .spl_tx_rd_almostfull(af),
        .io_tx_rd_valid(iov[1]), .io_tx_rd_addr(ioa[1]), .io_tx_rd_len(iol[1]),
        .io_rx_rd_valid(rsp[1]), .rd_outstanding(ocnt[1]), .rd_idle(idle[1]), .rd_err(err[1]),
        .rd_stall_af_cnt(saf[1]), .rd_stall_cr_cnt(scr[1])
    );

    // Reference model: lines left in the current burst, expected address queue, credit count.
    int          max_o [N] = '{64, 2};
    int          m_rem [N];
    int          m_cnt [N];
    bit          m_err [N];
    bit          m_ign [N];
    longint      m_af  [N];
    longint      m_cr  [N];
    logic [57:0] q0 [$];
    logic [57:0] q1 [$];
    int          due [$];
    int          mode [N];   // 0 none, 1 random, 2 six cycles after issue (inst 1), 3 drain
    int          seen [N];
    int          cyc;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input int i, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] got=%0h want=%0h", tag, i, obs, exp);
        end
    endtask

    function automatic logic [57:0] q_pop(input int i);
        if (i == 0) return (q0.size() > 0) ? q0.pop_front() : 58'h0;
        return (q1.size() > 0) ? q1.pop_front() : 58'h0;
    endfunction

    task automatic tick();
        bit          fire [N];
        bit          acc  [N];
        logic [57:0] ea   [N];
        bit          busy;
        bit          r;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < N; i++) begin
            fire[i] = 0;
            acc[i]  = 0;
            ea[i]   = '0;
            if (!reset_n) begin
                m_rem[i] = 0; m_cnt[i] = 0; m_err[i] = 0; m_ign[i] = 1;
                m_af[i] = 0; m_cr[i] = 0;
                if (i == 0) q0.delete(); else q1.delete();
            end else begin
                busy     = m_rem[i] > 0;
                r        = rsp[i] && !m_ign[i];
                m_ign[i] = 0;
                fire[i]  = busy && !af && (m_cnt[i] < max_o[i]);
                if (busy && af) begin
                    if (m_af[i] < 64'hFFFF_FFFF) m_af[i]++;
                end else if (busy && !fire[i]) begin
                    if (m_cr[i] < 64'hFFFF_FFFF) m_cr[i]++;
                end
                if (fire[i]) begin
                    ea[i] = q_pop(i);
                    m_rem[i]--;
                end else if (!busy && cv[i]) begin
                    acc[i]   = 1;
                    m_rem[i] = (cl[i] == 6'd0) ? 64 : int'(cl[i]);
                    for (int k = 0; k < m_rem[i]; k++) begin
                        if (i == 0) q0.push_back(ca[i] + 58'(k));
                        else        q1.push_back(ca[i] + 58'(k));
                    end
                end
                if (fire[i] && !r) m_cnt[i]++;
                else if (r && !fire[i]) begin
                    if (m_cnt[i] == 0) m_err[i] = 1;
                    else m_cnt[i]--;
                end
                if (fire[i] && i == 1) due.push_back(cyc + 5);
            end
        end
        #1;
        for (int i = 0; i < N; i++) begin
            chk("io_valid", i, iov[i], fire[i]);
            if (fire[i]) begin
                chk("io_addr", i, ioa[i], ea[i]);
                chk("io_len", i, iol[i], 1);
            end
            if (iov[i]) seen[i]++;
            chk("ready", i, ready[i], m_rem[i] == 0);
            chk("outstanding", i, ocnt[i], m_cnt[i]);
            chk("credit_bound", i, ocnt[i] <= max_o[i], 1);
            chk("idle", i, idle[i], (m_rem[i] == 0) && (m_cnt[i] == 0));
            chk("err", i, err[i], m_err[i]);
`ifdef RD_SPLIT_PERF_EN
            chk("stall_af", i, saf[i], m_af[i]);
            chk("stall_cr", i, scr[i], m_cr[i]);
`else
            chk("stall_af", i, saf[i], 0);
            chk("stall_cr", i, scr[i], 0);
`endif
            if (acc[i] || !reset_n) cv[i] = 1'b0;
        end
        if (!reset_n) due.delete();
        for (int i = 0; i < N; i++) begin
            case (mode[i])
                1: rsp[i] = (m_cnt[i] > 0) && ($urandom_range(1) == 1);
                2: begin
                    rsp[i] = 1'b0;
                    if (i == 1 && due.size() > 0 && due[0] <= cyc) begin
                        rsp[i] = 1'b1;
                        void'(due.pop_front());
                    end
                end
                3: rsp[i] = m_cnt[i] > 0;
                default: rsp[i] = 1'b0;
            endcase
        end
    endtask

    task automatic burst(input int i, input logic [57:0] a, input logic [5:0] l);
        ca[i] = a;
        cl[i] = l;
        cv[i] = 1'b1;
    endtask

    task automatic wait_done(input int i, input int budget);
        int b = 0;
        while ((cv[i] || m_rem[i] > 0) && b < budget) begin tick(); b++; end
        chk("wait_done", i, m_rem[i] == 0 && !cv[i], 1);
    endtask

    task automatic wait_seen(input int i, input int n, input int budget);
        int b = 0;
        while (seen[i] < n && b < budget) begin tick(); b++; end
        chk("wait_seen", i, seen[i] >= n, 1);
    endtask

    task automatic drain(input int i, input int budget);
        int b = 0;
        mode[i] = 3;
        while (m_cnt[i] > 0 && b < budget) begin tick(); b++; end
        mode[i] = 0;
        rsp[i]  = 1'b0;
        chk("drain", i, ocnt[i], 0);
    endtask

    initial begin
        int s;
        int b;
        af = 1'b0; cv = '0; ca = '0; cl = '0; rsp = '0;
        mode = '{0, 0}; seen = '{0, 0}; cyc = 0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Four-line burst, no stall.
        burst(0, 58'h100, 6'd4);
        wait_done(0, 50);
        chk("t1_seen", 0, seen[0], 4);
        chk("t1_cnt", 0, ocnt[0], 4);
        drain(0, 50);
        chk("t1_idle", 0, idle[0], 1);

        // Full 64-line burst with responses withheld, then a burst crossing the 58-bit wrap.
        s = seen[0];
        burst(0, 58'h3FF_FFFF_FFFF_FFC0, 6'd0);
        wait_done(0, 200);
        chk("t2_seen", 0, seen[0] - s, 64);
        chk("t2_cnt", 0, ocnt[0], 64);
        chk("t2_ready", 0, ready[0], 1);
        chk("t2_idle", 0, idle[0], 0);
        drain(0, 200);
        burst(0, {58{1'b1}} - 58'd2, 6'd5);
        wait_done(0, 50);
        chk("t2_wrap_addr", 0, ioa[0], 58'h1);
        drain(0, 50);

        // Two-credit instance with slow responses.
        mode[1] = 2;
        burst(1, 58'h2000, 6'd5);
        wait_done(1, 200);
        b = 0;
        while (m_cnt[1] > 0 && b < 100) begin tick(); b++; end
        mode[1] = 0;
        chk("t3_seen", 1, seen[1], 5);
        chk("t3_cnt", 1, ocnt[1], 0);
`ifdef RD_SPLIT_PERF_EN
        chk("t3_cr_nonzero", 1, scr[1] != 32'd0, 1);
`else
        chk("t3_cr_zero", 1, scr[1], 0);
`endif

        // Almost-full held for ten cycles after the third request.
        s = seen[0];
        burst(0, 58'h400, 6'd8);
        wait_seen(0, s + 3, 50);
        af = 1'b1;
        repeat (10) tick();
        af = 1'b0;
        wait_done(0, 50);
        chk("t4_seen", 0, seen[0] - s, 8);
`ifdef RD_SPLIT_PERF_EN
        chk("t4_af", 0, saf[0], 10);
`else
        chk("t4_af", 0, saf[0], 0);
`endif
        drain(0, 50);

        // Unmatched response, then fire and response on the same edge at count 3.
        rsp[0] = 1'b1;
        tick();
        chk("t5_err", 0, err[0], 1);
        chk("t5_cnt0", 0, ocnt[0], 0);
        s = seen[0];
        burst(0, 58'h800, 6'd4);
        wait_seen(0, s + 3, 50);
        rsp[0] = 1'b1;
        tick();
        chk("t5_cnt3", 0, ocnt[0], 3);
        chk("t5_seen", 0, seen[0] - s, 4);
        drain(0, 50);

        // Reset after two of six lines.
        s = seen[0];
        burst(0, 58'h1000, 6'd6);
        wait_seen(0, s + 2, 50);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("t6_ready", 0, ready[0], 1);
        chk("t6_valid", 0, iov[0], 0);
        chk("t6_addr", 0, ioa[0], 0);
        chk("t6_err", 0, err[0], 0);
        chk("t6_idle", 0, idle[0], 1);
        rsp[0] = 1'b1;
        tick();
        chk("t6_rsp_ignored", 0, err[0], 0);
        repeat (10) tick();
        chk("t6_no_more", 0, seen[0] - s, 2);

        // Randomized bursts, almost-full and responses on both instances.
        mode = '{1, 1};
        for (int c = 0; c < 1500; c++) begin
            af = ($urandom_range(4) == 0);
            for (int i = 0; i < N; i++) begin
                if (!cv[i] && m_rem[i] == 0 && $urandom_range(2) == 0) begin
                    if ($urandom_range(3) == 0)
                        burst(i, {58{1'b1}} - 58'($urandom_range(15)), 6'($urandom));
                    else
                        burst(i, 58'({$urandom, $urandom}), 6'($urandom));
                end
            end
            tick();
        end
        af = 1'b0;
        mode = '{3, 3};
        b = 0;
        while ((m_rem[0] > 0 || m_rem[1] > 0 || m_cnt[0] > 0 || m_cnt[1] > 0 || cv != '0)
               && b < 600) begin
            tick();
            b++;
        end
        chk("final_idle0", 0, idle[0], 1);
        chk("final_idle1", 1, idle[1], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
